// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the fetch stage and the decode-side blocks:
//   XLEN / ILEN    architectural register and instruction widths
//   INSTR_NOP      canonical NOP encoding (addi x0, x0, 0)
//   fetch_state_e  fetch sequencer states
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO used by the fetch stage, both for returned {instr, pc}
// entries and for the PCs of outstanding requests.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write an entry
//   pop                 drop the head entry
//   flush               discard all entries (wins over push/pop)
//   pop_data            current head entry (valid when !empty)
//   empty, full, count  occupancy status
// DEPTH must be a power of two so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same
    // cycle; the freed slot is the one being written.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            assert (flush || !(push && full && !pop));
            assert (flush || !(pop && empty));
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// -----------------------------------------------------------------------------
// ifetch_stage
// Instruction fetch: owns the PC, issues word requests to instruction memory,
// buffers returned words and hands {instr, pc} to decode over valid/ready.
// A redirect from execute flushes buffered words and marks every in-flight
// request stale so its response is discarded on arrival.
// Ports:
//   imem_req_valid/ready/addr   fetch request channel (addr = current PC)
//   imem_rsp_valid/data         in-order response channel
//   redirect_valid/pc           taken branch/jump target
//   out_valid/ready/instr/pc    instruction handed to decode
//   fetch_fault                 sticky misaligned-redirect trap
// Build option: define IFETCH_ALIGN_CHK_EN to trap misaligned redirect
// targets (fault + halt). Without it the target's low two bits are cleared
// and fetch_fault stays 0.
// -----------------------------------------------------------------------------
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ENT_W = ILEN + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic            fault_q, fault_d;

    logic [CNT_W-1:0] fifo_count;
    logic            fifo_empty, fifo_full;
    logic [ENT_W-1:0] fifo_head;
    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty, pcq_full;
    logic [CNT_W-1:0] pcq_count;

    logic [XLEN-1:0] redirect_tgt;
    logic            misalign;
    logic [CNT_W:0]  occupancy;
    logic            req_fire, rsp_keep, out_fire;

`ifdef IFETCH_ALIGN_CHK_EN
    assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
`else
    logic unused_redirect_lsbs;
    assign misalign             = 1'b0;
    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // In-flight requests count against buffer space, so every response that
    // can come back is guaranteed a FIFO slot.
    assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q == S_RUN) && !redirect_valid &&
                            (occupancy < (CNT_W+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response landing in a redirect cycle belongs to the old path.
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign out_valid            = !fifo_empty;
    assign {out_instr, out_pc}  = fifo_head;
    assign out_fire             = out_valid && out_ready;
    assign fetch_fault          = fault_q;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d     = drop_q;
        fault_d    = fault_q | misalign;
        state_d    = state_q;

        if (redirect_valid) begin
            pc_d   = redirect_tgt;
            // Everything still outstanding after this cycle is stale.
            drop_d = inflight_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end

        case (state_q)
            S_BOOT:  state_d = misalign ? S_HALT : S_RUN;
            S_RUN:   state_d = misalign ? S_HALT : S_RUN;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
        end
    end

    // PCs of live (non-stale) requests in issue order; responses are in order,
    // so the head is always the PC of the next kept response. A redirect
    // flushes it because every outstanding request becomes stale.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .pop_data  (pcq_head),
        .empty     (pcq_empty),
        .full      (pcq_full),
        .count     (pcq_count)
    );

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, pcq_head}),
        .pop       (out_fire),
        .flush     (redirect_valid),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    logic unused_status;
    assign unused_status = ^{pcq_empty, pcq_full, pcq_count, fifo_full};

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address a is a ^ 32'hDEAD_0000,
    // response 1 or 2 cycles after accept.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    int          lat;
    logic        mem_ready;
    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_a <= '0;
            s2_a <= '0;
        end else begin
            s1_v <= imem_req_valid && imem_req_ready;
            s1_a <= imem_req_addr;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    assign imem_req_ready = mem_ready;
    assign imem_rsp_valid = (lat == 1) ? s1_v : s2_v;
    assign imem_rsp_data  = instr_of((lat == 1) ? s1_a : s2_a);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a decode handshake, check it, step past the pop.
    task automatic expect_out(input string tag, input logic [31:0] pc);
        int waited;
        waited = 0;
        while (!(out_valid && out_ready) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!(out_valid && out_ready)) begin
            check({tag, "_timeout"}, 32'(out_valid), 32'd1);
        end else begin
            check({tag, "_pc"}, out_pc, pc);
            check({tag, "_instr"}, out_instr, instr_of(pc));
        end
        @(negedge clk);
    endtask

    task automatic redirect_once(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic        saw;
    int          waited;

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ready      = 1'b1;
        lat            = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // 1. Sequential fetch, first output after the third edge
        out_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c3", 32'(out_valid), 32'd1);
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("t1_seq%0d", i), exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        // 2. Backpressure: buffer fills, requests stop, then drains in order
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_fifo_count", 32'(dut.fifo_count), 32'd2);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("t2_drain%0d", i), exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        // 3. Redirect with two requests in flight (2-cycle memory)
        mem_ready = 1'b0;
        repeat (6) @(negedge clk);
        lat = 2;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_inflight", 32'(dut.inflight_q), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        check("t3_req_blocked", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t3_out_flushed", 32'(out_valid), 32'd0);
        check("t3_drop", 32'(dut.drop_q), 32'd1);
        expect_out("t3_a", 32'h0000_0100);
        expect_out("t3_b", 32'h0000_0104);
        expect_out("t3_c", 32'h0000_0108);

        // 4. Redirect on a response cycle, then a second redirect
        waited = 0;
        while (!imem_rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("t4_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        expect_out("t4_a", 32'h0000_0300);
        expect_out("t4_b", 32'h0000_0304);

        // 5. PC wrap
        redirect_once(32'hFFFF_FFFC);
        expect_out("t5_top", 32'hFFFF_FFFC);
        expect_out("t5_wrap", 32'h0000_0000);
        expect_out("t5_next", 32'h0000_0004);

        // 6. Misaligned redirect
        redirect_once(32'h0000_0102);
`ifdef IFETCH_ALIGN_CHK_EN
        check("t6_fault", 32'(fetch_fault), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) saw = 1'b1;
            @(negedge clk);
        end
        check("t6_no_req", 32'(saw), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
`else
        check("t6_no_fault", 32'(fetch_fault), 32'd0);
        expect_out("t6_aligned", 32'h0000_0100);
`endif

        // Reset mid-operation
        rst = 1'b1;
        #1;
        check("rst2_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst2_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_out("rst2_a", 32'h0000_0000);
        expect_out("rst2_b", 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
